// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command bridge: command word layout,
// opcodes and FSM state encodings.
package spi_cmd_pkg;

    localparam int OP_LSB   = 30;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        OP_NOP      = 2'b00,
        OP_STAGE_LO = 2'b01,
        OP_COMMIT   = 2'b10,
        OP_RSVD     = 2'b11
    } opcode_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_EXEC    = 2'd3;

    function automatic opcode_e get_op(input logic [31:0] word);
        return opcode_e'(word[OP_LSB +: 2]);
    endfunction

endpackage

// File: rtl/spi_cmd_bridge_if.sv
// Register-write request channel between the bridge and the SoC bus adapter.
interface spi_cmd_bridge_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    modport master (output req_valid, output req_addr, output req_wdata, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_wdata, output req_ready);
endinterface

// File: rtl/spi_cmd_fifo.sv
// Pending-write queue. A pop frees its slot in the same cycle, so a push into
// a full queue is still accepted when the head is being consumed.
module spi_cmd_fifo #(
    parameter int DW    = 46,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_empty;
    logic          w_full;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok   = i_pop & ~w_empty;
    assign w_push_ok  = i_push & (~w_full | w_pop_ok);
    assign o_overflow = i_push & w_full & ~w_pop_ok;
    assign o_valid    = ~w_empty;
    assign o_data     = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/spi_cmd_bridge.sv
// Moves the SPI slave's latched 32-bit word into the clk domain, decodes it as
// a command and queues 32-bit register writes for the bus adapter.
module spi_cmd_bridge
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_spi_ss,
    input  logic [31:0]       i_spi_word,
    spi_cmd_bridge_if.master  req,
    output logic [15:0]       o_frame_cnt,
    output logic              o_err_overflow,
    output logic              o_err_opcode
);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int DW    = ADDR_W + 32;

    logic              r_ss_meta;
    logic              r_ss_sync;
    logic              r_ss_d;
    logic              w_rise;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_word;
    logic [15:0]       r_lo_stage;
    logic [15:0]       r_frame_cnt;
    logic              r_err_overflow;
    logic              r_err_opcode;
    opcode_e           w_op;
    logic              w_push;
    logic [DW-1:0]     w_push_data;
    logic [DW-1:0]     w_head;
    logic              w_fifo_ovf;

    assign w_rise      = r_ss_sync & ~r_ss_d;
    assign w_op        = get_op(r_word);
    assign w_push      = (r_state == ST_EXEC) && (w_op == OP_COMMIT);
    assign w_push_data = {r_word[ADDR_LSB +: ADDR_W], r_word[DATA_LSB +: 16], r_lo_stage};

    // SS synchronizer and edge history; idle-high reset avoids a false rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ss_meta <= 1'b1;
            r_ss_sync <= 1'b1;
            r_ss_d    <= 1'b1;
        end else begin
            r_ss_meta <= i_spi_ss;
            r_ss_sync <= r_ss_meta;
            r_ss_d    <= r_ss_sync;
        end
    end

    // Frame FSM: wait for REG_DIN to settle, capture, then decode and act.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_word      <= 32'h0000_0000;
            r_lo_stage  <= 16'h0000;
            r_frame_cnt <= 16'h0000;
            r_err_opcode <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state     <= ST_WAIT;
                        r_cnt       <= '0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_cnt == CNT_W'(SETTLE - 1)) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_word  <= i_spi_word;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (w_op)
                        OP_STAGE_LO: r_lo_stage   <= r_word[DATA_LSB +: 16];
                        OP_RSVD:     r_err_opcode <= 1'b1;
                        default:     ;
                    endcase
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_overflow <= 1'b0;
        end else if (w_fifo_ovf) begin
            r_err_overflow <= 1'b1;
        end else begin
            r_err_overflow <= r_err_overflow;
        end
    end

    spi_cmd_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_data     (w_push_data),
        .i_pop      (req.req_ready),
        .o_data     (w_head),
        .o_valid    (req.req_valid),
        .o_overflow (w_fifo_ovf)
    );

    assign req.req_addr    = w_head[DW-1:32];
    assign req.req_wdata   = w_head[31:0];
    assign o_frame_cnt     = r_frame_cnt;
    assign o_err_overflow  = r_err_overflow;
    assign o_err_opcode    = r_err_opcode;

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Scoreboard bench for spi_cmd_bridge: stimulus pushes expected writes, a
// negedge monitor pops and compares every accepted request.
module tb_spi_cmd_bridge;
    localparam int SETTLE = 2;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        spi_ss   = 1'b1;
    logic [31:0] spi_word = 32'h0000_0000;
    logic        ready    = 1'b0;
    logic [15:0] frame_cnt;
    logic        err_ovf;
    logic        err_op;

    int          checks = 0;
    int          errors = 0;
    logic [45:0] exp_q[$];
    logic [45:0] mon_e;

    spi_cmd_bridge_if #(.ADDR_W(14)) bus ();
    assign bus.req_ready = ready;

    spi_cmd_bridge #(
        .ADDR_W     (14),
        .FIFO_DEPTH (4),
        .SETTLE     (SETTLE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_spi_ss       (spi_ss),
        .i_spi_word     (spi_word),
        .req            (bus),
        .o_frame_cnt    (frame_cnt),
        .o_err_overflow (err_ovf),
        .o_err_opcode   (err_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every request accepted by the consumer must match the queue head.
    always @(negedge clk) begin
        if (reset && bus.req_valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got addr %0h wdata %0h expected none",
                         bus.req_addr, bus.req_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("req", {18'h0, bus.req_addr, bus.req_wdata}, {18'h0, mon_e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        reset = 1'b1;
        tick();
    endtask

    task automatic raise(input logic [31:0] w);
        spi_ss = 1'b0;
        repeat (2) tick();
        spi_word = w;
        spi_ss   = 1'b1;
    endtask

    task automatic frame(input logic [31:0] w);
        raise(w);
        repeat (12) tick();
    endtask

    task automatic commit(input logic [13:0] a, input logic [15:0] d, input logic [15:0] lo, input bit expect_push);
        if (expect_push) exp_q.push_back({a, d, lo});
        frame({2'b10, a, d});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        // Test 1: reset state, no spurious frame on release
        repeat (2) tick();
        check("rst_valid", 64'(bus.req_valid), 64'd0);
        check("rst_addr", 64'(bus.req_addr), 64'd0);
        check("rst_wdata", 64'(bus.req_wdata), 64'd0);
        check("rst_frame", 64'(frame_cnt), 64'd0);
        check("rst_errs", {62'd0, err_ovf, err_op}, 64'd0);
        reset = 1'b1;
        repeat (10) tick();
        check("no_spurious_frame", 64'(frame_cnt), 64'd0);

        // Test 2: stage + commit, latency from SS rise at the pin
        frame(32'h4000_BEEF);
        exp_q.push_back({14'h0012, 32'hDEAD_BEEF});
        raise(32'h8012_DEAD);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.req_valid && n < 20);
        check("latency", 64'(n), 64'(2 + SETTLE + 3));
        check("frame_cnt2", 64'(frame_cnt), 64'd2);
        ready = 1'b1;
        drain();
        check("t2_valid_low", 64'(bus.req_valid), 64'd0);

        // Test 3: overflow with consumer stalled, then in-order drain
        ready = 1'b0;
        do_reset();
        frame(32'h4000_5555);
        for (int i = 1; i <= 5; i++) begin
            commit(14'(i), 16'hA000 + 16'(i), 16'h5555, i <= 4);
        end
        check("ovf_set", 64'(err_ovf), 64'd1);
        check("ovf_full_valid", 64'(bus.req_valid), 64'd1);
        check("frame_cnt6", 64'(frame_cnt), 64'd6);
        ready = 1'b1;
        drain();
        check("t3_valid_low", 64'(bus.req_valid), 64'd0);

        // Test 4: push into full FIFO while the head is popped
        ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            commit(14'(16 + i), 16'hB000 + 16'(i), 16'h0000, 1'b1);
        end
        exp_q.push_back({14'd21, 16'hB005, 16'h0000});
        raise({2'b10, 14'd21, 16'hB005});
        repeat (6) tick();
        check("t4_full", 64'(bus.req_valid), 64'd1);
        ready = 1'b1;
        drain();
        check("t4_no_ovf", 64'(err_ovf), 64'd0);

        // Test 5: reserved opcode and NOP
        do_reset();
        frame(32'hC000_0000);
        check("opcode_err", 64'(err_op), 64'd1);
        check("rsvd_no_req", 64'(bus.req_valid), 64'd0);
        frame(32'h4000_1111);
        frame(32'h0000_1234);
        check("nop_no_req", 64'(bus.req_valid), 64'd0);
        exp_q.push_back({14'd3, 32'h2222_1111});
        frame(32'h8003_2222);
        drain();
        check("t5_ovf_clear", 64'(err_ovf), 64'd0);

        // Test 6: reset during WAIT aborts the commit
        do_reset();
        raise(32'h8007_7777);
        repeat (4) tick();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (15) tick();
        check("abort_no_req", 64'(bus.req_valid), 64'd0);
        check("abort_frame0", 64'(frame_cnt), 64'd0);
        frame(32'h4000_BEEF);
        exp_q.push_back({14'h0012, 32'hDEAD_BEEF});
        frame(32'h8012_DEAD);
        drain();
        check("t6_frame_cnt2", 64'(frame_cnt), 64'd2);
        check("t6_err_op", 64'(err_op), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
